// File: rtl/red_pitaya_decimator_block.sv
// red_pitaya_decimator_block: power-of-two boxcar decimator with window min/max.
// Ports: clk_i/rst_i clock and sync active-high reset; dat_i input sample;
// dec_on averaging enable (0 = bypass); set_log log2 ratio, clamped to MAXLOG;
// restart_i aborts the current window; dat_o/min_o/max_o window average,
// minimum and maximum; valid_o one-cycle strobe marking new outputs.
module red_pitaya_decimator_block #(
    parameter int SIGNALBITS = 14,
    parameter int MAXLOG     = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic signed [SIGNALBITS-1:0] dat_i,
    input  logic                         dec_on,
    input  logic [3:0]                   set_log,
    input  logic                         restart_i,
    output logic signed [SIGNALBITS-1:0] dat_o,
    output logic signed [SIGNALBITS-1:0] min_o,
    output logic signed [SIGNALBITS-1:0] max_o,
    output logic                         valid_o
);
    localparam int AW = SIGNALBITS + MAXLOG;
    localparam logic [3:0] MAXL = 4'(MAXLOG);
    typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_t;
    state_t state_q, state_d;
    logic [MAXLOG-1:0] cnt_q, cnt_d, mask;
    logic [3:0] le_q, le_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [SIGNALBITS-1:0] wmin_q, wmin_d, wmax_q, wmax_d;
    logic signed [SIGNALBITS-1:0] dat_q, dat_d, min_q, min_d, max_q, max_d;
    logic valid_q, valid_d, run, first, last, strobe;
    always_comb begin
        run = state_q != IDLE;
        first = cnt_q == '0;
        // bypass is a window of one sample, so dec_on folds into the latched ratio
        le_d = first ? (dec_on ? ((set_log > MAXL) ? MAXL : set_log) : 4'd0) : le_q;
        mask = MAXLOG'(((MAXLOG+1)'(1) << le_d) - (MAXLOG+1)'(1));
        last = run && (cnt_q == mask);
        strobe = last && !restart_i;
        acc_d = first ? AW'(dat_i) : acc_q + AW'(dat_i);
        wmin_d = (first || dat_i < wmin_q) ? dat_i : wmin_q;
        wmax_d = (first || dat_i > wmax_q) ? dat_i : wmax_q;
        dat_d = strobe ? SIGNALBITS'(acc_d >>> le_d) : dat_q;
        min_d = strobe ? wmin_d : min_q;
        max_d = strobe ? wmax_d : max_q;
        valid_d = strobe;
        cnt_d = (!run || restart_i || last) ? '0 : cnt_q + MAXLOG'(1);
        state_d = strobe ? DUMP : ACCUM;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            le_q    <= '0;
            acc_q   <= '0;
            wmin_q  <= '0;
            wmax_q  <= '0;
            dat_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            le_q    <= le_d;
            acc_q   <= acc_d;
            wmin_q  <= wmin_d;
            wmax_q  <= wmax_d;
            dat_q   <= dat_d;
            min_q   <= min_d;
            max_q   <= max_d;
            valid_q <= valid_d;
        end
    end
    assign dat_o   = dat_q;
    assign min_o   = min_q;
    assign max_o   = max_q;
    assign valid_o = valid_q;
endmodule

// File: tb/tb_red_pitaya_decimator_block.sv
// tb_red_pitaya_decimator_block: vector table, corner sequences and random run against a window model.
module tb_red_pitaya_decimator_block;
    logic clk = 1'b0;
    logic rst_i = 1'b1, dec_on = 1'b1, restart_i = 1'b0;
    logic [3:0] set_log = 4'd0;
    logic signed [13:0] dat_i = '0;
    logic signed [13:0] dat_o, min_o, max_o;
    logic valid_o;

    red_pitaya_decimator_block dut (
        .clk_i(clk), .rst_i(rst_i), .dat_i(dat_i), .dec_on(dec_on), .set_log(set_log),
        .restart_i(restart_i), .dat_o(dat_o), .min_o(min_o), .max_o(max_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst, dec, rs;
        bit [3:0] sl;
        int dat;
        bit v;
        int d, mn, mx;
    } vec_t;
    vec_t tv[$];

    int vectors = 0, errors = 0, ncyc = 0;
    bit m_v = 0, m_idle = 1;
    int m_d = 0, m_mn = 0, m_mx = 0, wle = 0;
    int q[$];

    function automatic void add(bit r, bit dec, bit rs, bit [3:0] sl, int d, bit v, int ed, int emn, int emx);
        tv.push_back('{r, dec, rs, sl, d, v, ed, emn, emx});
    endfunction

    // behavioural reference: buffer the window's samples, reduce them when full
    function automatic void model(bit r, bit dec, bit rs, bit [3:0] sl, int d);
        int s, mn, mx;
        if (r) begin
            m_v = 0; m_d = 0; m_mn = 0; m_mx = 0; m_idle = 1; q.delete();
        end else if (m_idle) begin
            m_idle = 0; m_v = 0;
        end else begin
            if (q.size() == 0) wle = dec ? ((sl > 10) ? 10 : int'(sl)) : 0;
            q.push_back(d);
            m_v = 0;
            if (rs) q.delete();
            else if (q.size() == (1 << wle)) begin
                s = 0; mn = q[0]; mx = q[0];
                foreach (q[i]) begin
                    s += q[i];
                    if (q[i] < mn) mn = q[i];
                    if (q[i] > mx) mx = q[i];
                end
                m_d = s >>> wle; m_mn = mn; m_mx = mx; m_v = 1;
                q.delete();
            end
        end
    endfunction

    task automatic check(input string nm, input bit v, input int d, input int mn, input int mx);
        vectors++;
        if (valid_o !== v || int'(dat_o) != d || int'(min_o) != mn || int'(max_o) != mx) begin
            errors++;
            $display("FAIL %s cyc=%0d got v=%0b d=%0d mn=%0d mx=%0d want v=%0b d=%0d mn=%0d mx=%0d",
                     nm, ncyc, valid_o, dat_o, min_o, max_o, v, d, mn, mx);
        end
    endtask

    task automatic cyc(input bit r, input bit dec, input bit rs, input bit [3:0] sl, input int d);
        @(negedge clk);
        rst_i = r; dec_on = dec; restart_i = rs; set_log = sl; dat_i = 14'(d);
        @(posedge clk);
        ncyc++;
        model(r, dec, rs, sl, d);
        #1;
        check("model", m_v, m_d, m_mn, m_mx);
    endtask

    task automatic count_check(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    initial begin
        int hit;
        add(1, 1, 0, 2, 0, 0, 0, 0, 0);
        add(0, 1, 0, 2, 0, 0, 0, 0, 0);
        add(0, 1, 0, 2, 1, 0, 0, 0, 0);
        add(0, 1, 0, 2, 2, 0, 0, 0, 0);
        add(0, 1, 0, 2, 3, 0, 0, 0, 0);
        add(0, 1, 0, 2, 6, 1, 3, 1, 6);
        add(0, 1, 0, 2, 1, 0, 3, 1, 6);
        add(0, 1, 0, 2, 2, 0, 3, 1, 6);
        add(0, 1, 0, 2, 3, 0, 3, 1, 6);
        add(0, 1, 0, 2, 6, 1, 3, 1, 6);
        add(0, 1, 0, 1, -1, 0, 3, 1, 6);
        add(0, 1, 0, 1, 0, 1, -1, -1, 0);
        for (int i = 0; i < 7; i++) add(0, 1, 0, 3, -8192, 0, -1, -1, 0);
        add(0, 1, 0, 3, -8192, 1, -8192, -8192, -8192);
        add(0, 1, 0, 0, 5, 1, 5, 5, 5);
        add(0, 1, 0, 0, 7, 1, 7, 7, 7);
        add(0, 0, 0, 4, -3, 1, -3, -3, -3);
        add(0, 0, 0, 9, 8191, 1, 8191, 8191, 8191);
        foreach (tv[i]) begin
            cyc(tv[i].rst, tv[i].dec, tv[i].rs, tv[i].sl, tv[i].dat);
            check("table", tv[i].v, tv[i].d, tv[i].mn, tv[i].mx);
        end

        // restart on the third sample of an 8-sample window
        cyc(1, 1, 0, 3, 0);
        cyc(0, 1, 0, 3, 0);
        cyc(0, 1, 0, 3, 100);
        cyc(0, 1, 0, 3, 200);
        cyc(0, 1, 1, 3, 300);
        hit = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 1, 0, 3, 10 * k);
            if (valid_o && hit == 0) hit = k;
        end
        count_check("restart_strobe", hit, 8);

        // reset in the middle of a window
        for (int k = 0; k < 4; k++) cyc(0, 1, 0, 3, -50 * k);
        cyc(1, 1, 0, 3, 0);
        hit = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 1, 0, 3, k - 6);
            if (valid_o && hit == 0) hit = k;
        end
        count_check("reset_strobe", hit, 9);

        // clamped ratio, with set_log changed mid-window
        cyc(1, 1, 0, 15, 0);
        hit = 0;
        for (int k = 1; k <= 1100; k++) begin
            cyc(0, 1, 0, (k < 100) ? 4'd15 : 4'd2, int'($urandom_range(0, 16383)) - 8192);
            if (valid_o && hit == 0) hit = k;
        end
        count_check("clamp_strobe", hit, 1025);

        // bypass ramp
        cyc(1, 0, 0, 5, 0);
        hit = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 0, 0, 5, 40 * k - 400);
            if (valid_o) hit++;
        end
        count_check("bypass_valids", hit, 19);

        // random traffic
        for (int k = 0; k < 4000; k++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4)),
                int'($urandom_range(0, 16383)) - 8192);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/red_pitaya_decimator_block.md
RED_PITAYA_DECIMATOR_BLOCK -- requirements
Module: red_pitaya_decimator_block

Interface
REQ-001 SHALL have parameter SIGNALBITS, default 14: width of input and output samples.
REQ-002 SHALL have parameter MAXLOG, default 10: largest supported log2 decimation ratio.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port dat_i, input, SIGNALBITS bits, signed: filter-chain output, one sample per clock.
REQ-006 SHALL have port dec_on, input, 1 bit: 1 = averaging, 0 = bypass.
REQ-007 SHALL have port set_log, input, 4 bits: log2 decimation ratio L.
REQ-008 SHALL have port restart_i, input, 1 bit: single-cycle pulse that aborts the current window.
REQ-009 SHALL have port dat_o, output, SIGNALBITS bits, signed: averaged sample.
REQ-010 SHALL have port min_o, output, SIGNALBITS bits, signed: minimum of dat_i over the last completed window.
REQ-011 SHALL have port max_o, output, SIGNALBITS bits, signed: maximum of dat_i over the last completed window.
REQ-012 SHALL have port valid_o, output, 1 bit: one-cycle strobe marking new dat_o, min_o and max_o.

Function
REQ-013 SHALL form the effective ratio Le = min(set_log, MAXLOG), so every value above MAXLOG is clamped to MAXLOG.
REQ-014 SHALL latch Le and dec_on only in the first cycle of each window; changes inside a window take effect from the next window.
REQ-015 SHALL use a window length of N = 2^Le consecutive dat_i samples, one sample accepted every cycle, with no gaps between windows.
REQ-016 SHALL use an accumulator of SIGNALBITS+MAXLOG bits, signed; with no overflow possible, there is no wrap-around.
REQ-017 SHALL compute dat_o as sum >>> Le (arithmetic shift, rounding toward minus infinity), which is always in range, so no saturation logic is needed.
REQ-018 SHALL track window min and max with signed compares; the first sample of a window initialises both.
REQ-019 SHALL update dat_o, min_o and max_o and pulse valid_o high for exactly 1 cycle, one clock after the cycle in which the Nth sample is present on dat_i.
REQ-020 SHALL hold dat_o, min_o and max_o between strobes.
REQ-021 SHALL, when Le = 0 in averaging mode, give dat_o = dat_i delayed by 1 clock with valid_o high every cycle, and min_o = max_o = dat_o.
REQ-022 SHALL, in bypass mode (latched dec_on = 0), behave identically to REQ-021 regardless of set_log.
REQ-023 SHALL implement a state machine with states IDLE (after reset, 1 cycle), ACCUM (counting 0..N-1) and DUMP (a registered output update overlapping the first sample of the next window).
REQ-024 SHALL sequence the states IDLE->ACCUM, ACCUM->ACCUM while count < N-1, ACCUM->DUMP->ACCUM.
REQ-025 SHALL, on restart_i = 1, discard the partial sum and count, produce no valid_o for the aborted window, and treat the next cycle as the first sample of a new window with freshly latched Le and dec_on.
REQ-026 SHALL, when restart_i coincides with the last sample of a window, suppress that window's strobe (restart wins).
REQ-027 SHALL NOT suppress a valid_o already scheduled in the cycle of restart_i, i.e. restart_i in the DUMP cycle.

Reset
REQ-028 SHALL, with rst_i high at a clock edge, clear dat_o, min_o, max_o, accumulator and counter to 0, drive valid_o to 0, and enter IDLE.
REQ-029 SHALL, if rst_i occurs mid-window, discard that window with no valid_o.
REQ-030 SHALL begin the first window on the second cycle after rst_i is released, with the IDLE cycle sample not accumulated.
REQ-031 SHALL hold all outputs at reset values until the first strobe.

Verification
REQ-032 SHALL be verified with: set_log=2, dec_on=1, dat_i = 1,2,3,6 repeated -> valid_o every 4 cycles, dat_o=3, min_o=1, max_o=6.
REQ-033 SHALL be verified with: set_log=3, dat_i constant -8192 for 8 cycles -> dat_o=-8192, with no overflow.
REQ-034 SHALL be verified with: set_log=1, dat_i = -1,0 -> dat_o=-1 (floor rounding).
REQ-035 SHALL be verified with: set_log=15 -> window of 1024 samples (clamped to MAXLOG=10); set_log changed mid-window -> the old N is kept until the strobe.
REQ-036 SHALL be verified with: dec_on=0, dat_i ramp -> dat_o = ramp delayed 1 cycle, valid_o continuously 1.
REQ-037 SHALL be verified with: restart_i pulse at sample 3 of an 8-sample window, and separately rst_i mid-window -> no strobe for the aborted window, next strobe exactly 8 samples after the restart (or after the IDLE cycle following reset).
